// File: rtl/pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pwm_ramp_ctrl
// Purpose  : Command-driven PWM sequencer; ramps DutyCycle toward a target in
//            steps applied only on PWM period boundaries.
// Option   : PWM_RAMP_SOFTSTOP_EN - Abort during a ramp ramps down to 0.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_ramp_ctrl #(
  parameter int MAX_DUTY       = 100,
  parameter int DEFAULT_PERIOD = 256
) (
  input  logic        SysClk,
  input  logic        Reset,
  input  logic        CmdValid,
  output logic        CmdReady,
  input  logic [15:0] CmdPeriod,
  input  logic [7:0]  CmdDuty,
  input  logic [7:0]  CmdStep,
  input  logic [7:0]  CmdInterval,
  input  logic        CmdBurst,
  input  logic        CmdBurstType,
  input  logic        Abort,
  output logic [15:0] Period,
  output logic [7:0]  DutyCycle,
  output logic        Burst,
  output logic        BurstType,
  output logic        PeriodTick,
  output logic        Busy,
  output logic        Done
);

  localparam logic [7:0]  c_max_duty       = (MAX_DUTY > 255) ? 8'd255 :
                                             (MAX_DUTY < 0)   ? 8'd0   : 8'(MAX_DUTY);
  localparam logic [15:0] c_default_period = 16'(DEFAULT_PERIOD);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RAMP = 2'd1,
    S_STOP = 2'd2
  } state_t;

  state_t      r_state,      w_state_nxt;
  logic [15:0] r_period,     w_period_nxt;
  logic [15:0] r_pcnt,       w_pcnt_nxt;
  logic [7:0]  r_duty,       w_duty_nxt;
  logic        r_burst,      w_burst_nxt;
  logic        r_burst_type, w_burst_type_nxt;
  logic        r_done,       w_done_nxt;
  logic [7:0]  r_target,     w_target_nxt;
  logic [7:0]  r_step,       w_step_nxt;
  logic [7:0]  r_interval,   w_interval_nxt;
  logic [7:0]  r_icnt,       w_icnt_nxt;

  logic       w_tick;
  logic       w_accept;
  logic       w_interval_hit;
  logic [8:0] w_icnt_inc;
  logic [7:0] w_goal;
  logic [7:0] w_stepped;
  logic [8:0] w_up;
  logic [8:0] w_gap;

  // Period 0 and 1 both degenerate to a tick on every cycle.
  assign w_tick   = !Reset && ((r_period <= 16'd1) || (r_pcnt == r_period - 16'd1));
  assign CmdReady = !Reset && (r_state == S_IDLE) && !Abort;
  assign w_accept = CmdValid && CmdReady;

  assign w_icnt_inc     = {1'b0, r_icnt} + 9'd1;
  assign w_interval_hit = (w_icnt_inc >= {1'b0, r_interval});

  // One saturating step of DutyCycle toward the goal; never overshoots.
  always_comb begin
    w_goal    = (r_state == S_STOP) ? 8'd0 : r_target;
    w_up      = {1'b0, r_duty} + {1'b0, r_step};
    w_gap     = {1'b0, r_duty} - {1'b0, w_goal};
    w_stepped = w_goal;
    if (r_step != 8'd0) begin
      if (r_duty < w_goal) begin
        if (w_up < {1'b0, w_goal}) begin
          w_stepped = w_up[7:0];
        end
      end else if (w_gap > {1'b0, r_step}) begin
        w_stepped = r_duty - r_step;
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_period_nxt     = r_period;
    w_pcnt_nxt       = w_tick ? 16'd0 : (r_pcnt + 16'd1);
    w_duty_nxt       = r_duty;
    w_burst_nxt      = r_burst;
    w_burst_type_nxt = r_burst_type;
    w_done_nxt       = 1'b0;
    w_target_nxt     = r_target;
    w_step_nxt       = r_step;
    w_interval_nxt   = r_interval;
    w_icnt_nxt       = r_icnt;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_target_nxt     = (CmdDuty > c_max_duty) ? c_max_duty : CmdDuty;
          w_step_nxt       = CmdStep;
          w_interval_nxt   = (CmdInterval == 8'd0) ? 8'd1 : CmdInterval;
          w_period_nxt     = CmdPeriod;
          w_burst_nxt      = CmdBurst;
          w_burst_type_nxt = CmdBurstType;
          w_pcnt_nxt       = 16'd0;
          w_icnt_nxt       = 8'd0;
          w_state_nxt      = S_RAMP;
        end
      end
      S_RAMP, S_STOP: begin
        if (w_tick) begin
          if (r_duty == w_goal) begin
            w_done_nxt  = 1'b1;
            w_icnt_nxt  = 8'd0;
            w_state_nxt = S_IDLE;
            if (r_state == S_STOP) begin
              w_burst_nxt = 1'b0;
            end
          end else if (w_interval_hit) begin
            w_icnt_nxt = 8'd0;
            w_duty_nxt = w_stepped;
            if (w_stepped == w_goal) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = S_IDLE;
              if (r_state == S_STOP) begin
                w_burst_nxt = 1'b0;
              end
            end
          end else begin
            w_icnt_nxt = w_icnt_inc[7:0];
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

`ifdef PWM_RAMP_SOFTSTOP_EN
    // Abort mid-ramp hands over to a ramp-down; Abort while stopping is ignored.
    if (Abort && (r_state == S_RAMP)) begin
      w_state_nxt = S_STOP;
      w_duty_nxt  = r_duty;
      w_burst_nxt = r_burst;
      w_icnt_nxt  = 8'd0;
      w_done_nxt  = 1'b0;
    end else if (Abort && (r_state == S_IDLE)) begin
      w_duty_nxt  = 8'd0;
      w_burst_nxt = 1'b0;
      w_done_nxt  = 1'b0;
    end
`else
    if (Abort) begin
      w_state_nxt = S_IDLE;
      w_duty_nxt  = 8'd0;
      w_burst_nxt = 1'b0;
      w_icnt_nxt  = 8'd0;
      w_done_nxt  = 1'b0;
    end
`endif
  end

  always_ff @(posedge SysClk) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_period     <= c_default_period;
      r_pcnt       <= 16'd0;
      r_duty       <= 8'd0;
      r_burst      <= 1'b0;
      r_burst_type <= 1'b0;
      r_done       <= 1'b0;
      r_target     <= 8'd0;
      r_step       <= 8'd0;
      r_interval   <= 8'd0;
      r_icnt       <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_period     <= w_period_nxt;
      r_pcnt       <= w_pcnt_nxt;
      r_duty       <= w_duty_nxt;
      r_burst      <= w_burst_nxt;
      r_burst_type <= w_burst_type_nxt;
      r_done       <= w_done_nxt;
      r_target     <= w_target_nxt;
      r_step       <= w_step_nxt;
      r_interval   <= w_interval_nxt;
      r_icnt       <= w_icnt_nxt;
    end
  end

  assign Period     = r_period;
  assign DutyCycle  = r_duty;
  assign Burst      = r_burst;
  assign BurstType  = r_burst_type;
  assign PeriodTick = w_tick;
  assign Busy       = !Reset && (r_state != S_IDLE);
  assign Done       = r_done;

endmodule
`default_nettype wire

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
Command-driven controller that configures and sequences the pwm block: it drives the Period, DutyCycle, Burst and BurstType inputs of one pwm instance. It accepts a profile over a valid/ready handshake, then ramps DutyCycle from its current value toward a target in fixed steps, applying changes only at PWM period boundaries. It provides soft-start and glitch-free retargeting for the PWM datapath.

Parameters:
MAX_DUTY, 100, ceiling applied to every DutyCycle value driven out.
DEFAULT_PERIOD, 256, Period output value after reset.

Ports:
SysClk  input  1  system clock; all logic on rising edge.
Reset  input  1  synchronous, active-high reset.
CmdValid  input  1  command present.
CmdReady  output  1  controller can accept a command.
CmdPeriod  input  16  PWM period for the command.
CmdDuty  input  8  target duty code.
CmdStep  input  8  duty increment per step; 0 = jump directly to target.
CmdInterval  input  8  PWM periods between steps; 0 treated as 1.
CmdBurst  input  1  Burst value to apply.
CmdBurstType  input  1  BurstType value to apply.
Abort  input  1  stop the current ramp.
Period  output  16  to pwm Period.
DutyCycle  output  8  to pwm DutyCycle.
Burst  output  1  to pwm Burst.
BurstType  output  1  to pwm BurstType.
PeriodTick  output  1  one-cycle pulse on the last cycle of each PWM period.
Busy  output  1  high outside IDLE.
Done  output  1  one-cycle pulse when DutyCycle reaches target.

Behaviour:
- Reset: Period=DEFAULT_PERIOD, DutyCycle=0, Burst=0, BurstType=0, PeriodTick=0, Busy=0, Done=0, CmdReady=0 during reset; state IDLE; all counters 0.
- Period counter: 16-bit, counts 0..Period-1, then wraps to 0. Period=0 or 1 gives PeriodTick every cycle. PeriodTick is asserted while counter==Period-1. The counter runs in all states.
- CmdReady = (state==IDLE) && !Abort. Accept = CmdValid && CmdReady.
- On accept, all of the following take effect on the next cycle:
  - latch target = min(CmdDuty, MAX_DUTY), step, and interval.
  - Period, Burst and BurstType take the command values.
  - period counter restarts at 0; interval counter cleared.
  - state RAMP.
- RAMP:
  - Each PeriodTick increments the interval counter. When it reaches interval, the counter clears and DutyCycle moves toward target by step.
  - Arithmetic is 9-bit and saturates at target: no overshoot, no wrap below 0 or above 255. step=0 means DutyCycle=target.
  - The update that makes DutyCycle==target pulses Done in the same cycle as the update; state returns to IDLE.
  - If target==DutyCycle at accept, Done pulses on the first PeriodTick and state returns to IDLE.
- Abort (any state):
  - Next cycle: DutyCycle=0, Burst=0, state IDLE, no Done.
  - Period and BurstType are held.
  - Abort and CmdValid in the same cycle: Abort wins and the command is not accepted.
- Outputs hold their values in IDLE. DutyCycle is never updated mid-period except on accept or Abort.
- Reset asserted mid-ramp returns all outputs to reset values on the next edge.
- Latency: accept to new Period/Burst = 1 cycle. First duty step = interval PeriodTicks after accept.

Optional Feature:
PWM_RAMP_SOFTSTOP_EN
- Defined:
  - Abort in RAMP enters state STOP instead of IDLE.
  - STOP ramps DutyCycle down toward 0 with the latched step and interval, using the same period-boundary rule and saturation.
  - When DutyCycle reaches 0: Burst=0, Done pulses, state IDLE.
  - Busy stays high and CmdReady stays low in STOP. Abort during STOP is ignored.
  - Abort in IDLE behaves as in the base behaviour.
- Undefined: no STOP state; Abort behaves as in the base behaviour.

Test Plan:
- Reset held 2 cycles, then released -> Period=256, DutyCycle=0, Burst=0, Busy=0, CmdReady=1.
- Cmd Period=10, Duty=25, Step=10, Interval=1, Burst=1, BurstType=1 -> DutyCycle goes 10, 20, 25 on successive PeriodTicks, 10 cycles apart; Done pulses with 25; Busy falls the next cycle.
- Cmd Duty=200 with MAX_DUTY=100, Step=0, Period=4 -> DutyCycle=100 at the first PeriodTick (cycle 4 after accept), Done in the same cycle.
- Starting at DutyCycle=100, cmd Duty=30, Step=50, Interval=2, Period=3 -> DutyCycle goes 50 then 30, each 6 cycles apart; never below 30.
- Mid-ramp, Abort asserted together with CmdValid -> command not accepted; next cycle DutyCycle=0, Burst=0, Busy=0; no Done. With PWM_RAMP_SOFTSTOP_EN, DutyCycle instead steps down to 0 and Done pulses.
- Reset asserted mid-ramp at DutyCycle=20 -> next cycle all outputs at reset values; a new command after release is accepted normally.
